// File: rtl/rf_write_scheduler.sv
// Write-port arbiter and pending-write scoreboard for the 8 x 16 decode register file.
// Define RF_SCHED_ROUND_ROBIN_EN for round-robin ALU/load arbitration (default: load always wins).
module rf_write_scheduler #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3,
  parameter int NREG   = 2 ** ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [WIDTH-1:0]  alu_data,
  output logic              alu_ready,
  input  logic              mem_valid,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [WIDTH-1:0]  mem_data,
  output logic              mem_ready,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_addr,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic              ra_used,
  input  logic              rb_used,
  output logic              stall,
  output logic              writeEnable,
  output logic [ADDR_W-1:0] writeAddr,
  output logic [WIDTH-1:0]  d
);

  logic              weQ, weD;
  logic [ADDR_W-1:0] waddrQ, waddrD;
  logic [WIDTH-1:0]  wdataQ, wdataD;
  logic [1:0]        countQ [NREG];
  logic [1:0]        countD [NREG];
  logic              aluWinsTie;
  logic              issueFire;

`ifdef RF_SCHED_ROUND_ROBIN_EN
  // lastMemQ resets high so the ALU takes the first tie after reset.
  logic lastMemQ, lastMemD;

  assign aluWinsTie = lastMemQ;

  always_comb begin
    lastMemD = lastMemQ;
    if (mem_ready)
      lastMemD = 1'b1;
    else if (alu_ready)
      lastMemD = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      lastMemQ <= 1'b1;
    else
      lastMemQ <= lastMemD;
  end
`else
  assign aluWinsTie = 1'b0;
`endif

  // Readies are masked by reset so nothing is accepted while reset is held.
  assign alu_ready = reset & alu_valid & (~mem_valid | aluWinsTie);
  assign mem_ready = reset & mem_valid & ~(alu_valid & aluWinsTie);

  always_comb begin
    weD    = alu_ready | mem_ready;
    waddrD = waddrQ;
    wdataD = wdataQ;
    if (mem_ready) begin
      waddrD = mem_addr;
      wdataD = mem_data;
    end else if (alu_ready) begin
      waddrD = alu_addr;
      wdataD = alu_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      weQ    <= 1'b0;
      waddrQ <= '0;
      wdataQ <= '0;
    end else begin
      weQ    <= weD;
      waddrQ <= waddrD;
      wdataQ <= wdataD;
    end
  end

  assign writeEnable = weQ;
  assign writeAddr   = waddrQ;
  assign d           = wdataQ;

  assign issue_ready = (countQ[issue_addr] != 2'd3);
  assign issueFire   = issue_valid & issue_ready;

  // Same-cycle issue and retire of one register cancel; a retire at zero saturates.
  always_comb begin
    for (int i = 0; i < NREG; i++) begin
      countD[i] = countQ[i];
      if (issueFire && issue_addr == ADDR_W'(i) && !(weQ && waddrQ == ADDR_W'(i)))
        countD[i] = countQ[i] + 2'd1;
      else if (!(issueFire && issue_addr == ADDR_W'(i)) && weQ && waddrQ == ADDR_W'(i)
               && countQ[i] != 2'd0)
        countD[i] = countQ[i] - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++)
        countQ[i] <= 2'd0;
    end else begin
      for (int i = 0; i < NREG; i++)
        countQ[i] <= countD[i];
    end
  end

  assign stall = (ra_used & (countQ[ra] != 2'd0))
               | (rb_used & (countQ[rb] != 2'd0))
               | (issue_valid & ~issue_ready);

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: vector table for arbitration plus hand sequences
// for scoreboard, stall timing and reset corner cases.
module tb_rf_write_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid, mem_valid, issue_valid, ra_used, rb_used;
  logic [2:0]  alu_addr, mem_addr, issue_addr, ra, rb;
  logic [15:0] alu_data, mem_data;
  logic        alu_ready, mem_ready, issue_ready, stall, writeEnable;
  logic [2:0]  writeAddr;
  logic [15:0] d;

  int testsRun = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  rf_write_scheduler #(.WIDTH(16), .ADDR_W(3), .NREG(8)) dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ready(mem_ready),
    .issue_valid(issue_valid), .issue_addr(issue_addr), .issue_ready(issue_ready),
    .ra(ra), .rb(rb), .ra_used(ra_used), .rb_used(rb_used), .stall(stall),
    .writeEnable(writeEnable), .writeAddr(writeAddr), .d(d)
  );

  typedef struct {
    logic        av;
    logic [2:0]  aa;
    logic [15:0] ad;
    logic        mv;
    logic [2:0]  ma;
    logic [15:0] md;
    logic        expAr;
    logic        expMr;
    logic        expWe;
    logic [2:0]  expAddr;
    logic [15:0] expD;
  } vec_t;

  vec_t vecs [8];

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    alu_valid = 0; alu_addr = 0; alu_data = 0;
    mem_valid = 0; mem_addr = 0; mem_data = 0;
    issue_valid = 0; issue_addr = 0;
    ra = 0; rb = 0; ra_used = 0; rb_used = 0;
  endtask

  task automatic doReset();
    reset = 0;
    clearInputs();
    step();
    reset = 1;
    #1;
  endtask

  task automatic applyStimulus(input vec_t v);
    alu_valid = v.av; alu_addr = v.aa; alu_data = v.ad;
    mem_valid = v.mv; mem_addr = v.ma; mem_data = v.md;
  endtask

  initial begin
    // Arbitration vectors; issue is idle so no write touches a pending count.
    vecs[0] = '{1, 3'd1, 16'h1111, 0, 3'd0, 16'h0000, 1, 0, 1, 3'd1, 16'h1111};
    vecs[1] = '{0, 3'd0, 16'h0000, 1, 3'd2, 16'h2222, 0, 1, 1, 3'd2, 16'h2222};
    vecs[2] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd2, 16'h2222};
`ifdef RF_SCHED_ROUND_ROBIN_EN
    vecs[3] = '{1, 3'd3, 16'h0033, 1, 3'd4, 16'h0044, 1, 0, 1, 3'd3, 16'h0033};
    vecs[4] = '{1, 3'd3, 16'h0033, 1, 3'd4, 16'h0044, 0, 1, 1, 3'd4, 16'h0044};
    vecs[5] = '{1, 3'd7, 16'h7777, 0, 3'd0, 16'h0000, 1, 0, 1, 3'd7, 16'h7777};
`else
    vecs[3] = '{1, 3'd3, 16'h0033, 1, 3'd4, 16'h0044, 0, 1, 1, 3'd4, 16'h0044};
    vecs[4] = '{1, 3'd3, 16'h0033, 1, 3'd5, 16'h0055, 0, 1, 1, 3'd5, 16'h0055};
    vecs[5] = '{1, 3'd3, 16'h0033, 0, 3'd0, 16'h0000, 1, 0, 1, 3'd3, 16'h0033};
`endif
    vecs[6] = '{0, 3'd0, 16'h0000, 1, 3'd0, 16'hFFFF, 0, 1, 1, 3'd0, 16'hFFFF};
    vecs[7] = '{0, 3'd0, 16'h0000, 0, 3'd0, 16'h0000, 0, 0, 0, 3'd0, 16'hFFFF};

    // Reset held with a pending ALU request.
    reset = 0;
    clearInputs();
    alu_valid = 1;
    #3;
    checkOutput("rst_we", writeEnable, 0);
    checkOutput("rst_addr", writeAddr, 0);
    checkOutput("rst_d", d, 0);
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_alu_ready", alu_ready, 0);
    step();
    checkOutput("rst_alu_ready_held", alu_ready, 0);
    reset = 1;
    #1;
    checkOutput("rel_alu_ready", alu_ready, 1);
    alu_valid = 0;
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("v%0d_alu_ready", i), alu_ready, vecs[i].expAr);
      checkOutput($sformatf("v%0d_mem_ready", i), mem_ready, vecs[i].expMr);
      checkOutput($sformatf("v%0d_stall", i), stall, 0);
      step();
      checkOutput($sformatf("v%0d_we", i), writeEnable, vecs[i].expWe);
      checkOutput($sformatf("v%0d_addr", i), writeAddr, vecs[i].expAddr);
      checkOutput($sformatf("v%0d_d", i), d, vecs[i].expD);
    end
    clearInputs();

    // Single write: stall on r1 spans issue+1 through the writeEnable cycle.
    doReset();
    issue_valid = 1; issue_addr = 1; ra = 1; ra_used = 1;
    #1;
    checkOutput("sw_c0_stall", stall, 0);
    step();
    issue_valid = 0;
    #1;
    checkOutput("sw_c1_stall", stall, 1);
    step();
    alu_valid = 1; alu_addr = 1; alu_data = 16'h0005;
    #1;
    checkOutput("sw_c2_alu_ready", alu_ready, 1);
    checkOutput("sw_c2_stall", stall, 1);
    step();
    alu_valid = 0;
    #1;
    checkOutput("sw_c3_we", writeEnable, 1);
    checkOutput("sw_c3_addr", writeAddr, 1);
    checkOutput("sw_c3_d", d, 16'h0005);
    checkOutput("sw_c3_stall", stall, 1);
    step();
    checkOutput("sw_c4_stall", stall, 0);
    checkOutput("sw_c4_we", writeEnable, 0);
    clearInputs();

    // Conflict from a fresh reset.
    doReset();
    alu_valid = 1; alu_addr = 2; alu_data = 16'h00AA;
    mem_valid = 1; mem_addr = 3; mem_data = 16'h00BB;
    #1;
`ifdef RF_SCHED_ROUND_ROBIN_EN
    checkOutput("cf1_alu_ready", alu_ready, 1);
    checkOutput("cf1_mem_ready", mem_ready, 0);
    step();
    checkOutput("cf1_addr", writeAddr, 2);
    checkOutput("cf1_d", d, 16'h00AA);
    #1;
    checkOutput("cf2_alu_ready", alu_ready, 0);
    checkOutput("cf2_mem_ready", mem_ready, 1);
    step();
    checkOutput("cf2_we", writeEnable, 1);
    checkOutput("cf2_addr", writeAddr, 3);
    checkOutput("cf2_d", d, 16'h00BB);
`else
    checkOutput("cf1_alu_ready", alu_ready, 0);
    checkOutput("cf1_mem_ready", mem_ready, 1);
    step();
    checkOutput("cf1_addr", writeAddr, 3);
    checkOutput("cf1_d", d, 16'h00BB);
    mem_valid = 0;
    #1;
    checkOutput("cf2_alu_ready", alu_ready, 1);
    checkOutput("cf2_mem_ready", mem_ready, 0);
    step();
    checkOutput("cf2_we", writeEnable, 1);
    checkOutput("cf2_addr", writeAddr, 2);
    checkOutput("cf2_d", d, 16'h00AA);
`endif
    clearInputs();

    // Saturate r5, then retire one write.
    issue_addr = 5;
    for (int k = 0; k < 3; k++) begin
      issue_valid = 1;
      #1;
      checkOutput($sformatf("sat_issue%0d_ready", k), issue_ready, 1);
      step();
    end
    #1;
    checkOutput("sat_full_ready", issue_ready, 0);
    checkOutput("sat_full_stall", stall, 1);
    issue_valid = 0;
    alu_valid = 1; alu_addr = 5; alu_data = 16'h0505;
    #1;
    checkOutput("sat_wr_alu_ready", alu_ready, 1);
    step();
    alu_valid = 0;
    #1;
    checkOutput("sat_wr_we", writeEnable, 1);
    checkOutput("sat_wr_still_full", issue_ready, 0);
    step();
    issue_valid = 1;
    #1;
    checkOutput("sat_after_ready", issue_ready, 1);
    checkOutput("sat_after_stall", stall, 0);
    clearInputs();

    // Issue and retire of r4 in the same cycle leaves its count at 1.
    doReset();
    issue_valid = 1; issue_addr = 4;
    step();
    issue_valid = 0;
    alu_valid = 1; alu_addr = 4; alu_data = 16'h0444;
    step();
    alu_valid = 0;
    issue_valid = 1; issue_addr = 4; rb = 4; rb_used = 1;
    #1;
    checkOutput("sim_we", writeEnable, 1);
    checkOutput("sim_stall_during", stall, 1);
    step();
    issue_valid = 0;
    #1;
    checkOutput("sim_stall_after", stall, 1);
    step();
    checkOutput("sim_stall_later", stall, 1);
    clearInputs();

    // Reset right after an acceptance drops the write and clears counts.
    issue_valid = 1; issue_addr = 6;
    step();
    issue_valid = 0;
    alu_valid = 1; alu_addr = 6; alu_data = 16'h0666;
    #1;
    checkOutput("mid_alu_ready", alu_ready, 1);
    step();
    reset = 0;
    alu_valid = 0;
    #1;
    checkOutput("mid_we", writeEnable, 0);
    checkOutput("mid_addr", writeAddr, 0);
    checkOutput("mid_d", d, 0);
    step();
    checkOutput("mid_we_held", writeEnable, 0);
    reset = 1;
    ra = 4; ra_used = 1; rb = 6; rb_used = 1;
    #1;
    checkOutput("mid_stall", stall, 0);
    step();
    checkOutput("mid_we_after", writeEnable, 0);
    checkOutput("mid_stall_after", stall, 0);
    clearInputs();

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
